// File: rtl/bitscan_if.sv
// Issue/result handshake bundle for the bit-scan unit: operand side and result side.
interface bitscan_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/bitscan_unit.sv
// Multi-cycle CLZ/CTZ/CPOP unit, CHUNK bits per RUN cycle, valid/ready on both sides.
// Optional BITSCAN_EARLY_EXIT_EN: CLZ/CTZ finish on the cycle the first 1 is found.
module bitscan_unit #(
    parameter int CHUNK = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    bitscan_if.slave  bus,
    output logic      busy
);
    localparam int NCHUNK = 32 / CHUNK;
    localparam int CW     = $clog2(NCHUNK);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    localparam logic [1:0] OP_CLZ  = 2'b00;
    localparam logic [1:0] OP_CTZ  = 2'b01;
    localparam logic [1:0] OP_CPOP = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   shift_reg, shift_next;
    logic [1:0]    op_reg, op_next;
    logic [5:0]    count_reg, count_next;
    logic          found_reg, found_next;
    logic [CW-1:0] chunk_reg, chunk_next;

    // CTZ reuses the CLZ datapath on the mirrored operand.
    logic [31:0] rev_data;
    for (genvar gi = 0; gi < 32; gi++) begin : g_rev
        assign rev_data[gi] = bus.in_data[31-gi];
    end

    logic [CHUNK-1:0] top_bits;
    logic [3:0]       chunk_lz;
    logic [3:0]       chunk_pop;
    logic             chunk_has_one;

    assign top_bits      = shift_reg[31 -: CHUNK];
    assign chunk_has_one = |top_bits;

    // Ascending scan: the highest set bit is the last to write chunk_lz.
    always_comb begin
        chunk_lz  = 4'(CHUNK);
        chunk_pop = 4'd0;
        for (int i = 0; i < CHUNK; i++) begin
            if (top_bits[i]) chunk_lz = 4'(CHUNK - 1 - i);
            chunk_pop = chunk_pop + {3'b000, top_bits[i]};
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        op_next    = op_reg;
        count_next = count_reg;
        found_next = found_reg;
        chunk_next = chunk_reg;
        if (flush) begin
            state_next = IDLE;
            count_next = 6'd0;
            found_next = 1'b0;
            chunk_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_next = (bus.in_op == OP_CTZ) ? rev_data : bus.in_data;
                        op_next    = bus.in_op;
                        count_next = 6'd0;
                        found_next = 1'b0;
                        chunk_next = '0;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    shift_next = shift_reg << CHUNK;
                    chunk_next = chunk_reg + CW'(1);
                    case (op_reg)
                        OP_CLZ, OP_CTZ: begin
                            if (!found_reg) begin
                                count_next = count_reg + {2'b00, chunk_lz};
                                if (chunk_has_one) found_next = 1'b1;
                            end
                        end
                        OP_CPOP: count_next = count_reg + {2'b00, chunk_pop};
                        default: ;
                    endcase
                    if (chunk_reg == LAST_CHUNK) state_next = DONE;
`ifdef BITSCAN_EARLY_EXIT_EN
                    if (!op_reg[1] && !found_reg && chunk_has_one) state_next = DONE;
`endif
                end
                DONE: begin
                    if (bus.out_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= 32'd0;
            op_reg    <= 2'b00;
            count_reg <= 6'd0;
            found_reg <= 1'b0;
            chunk_reg <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            op_reg    <= op_next;
            count_reg <= count_next;
            found_reg <= found_next;
            chunk_reg <= chunk_next;
        end
    end

    assign bus.in_ready   = (state_reg == IDLE);
    assign bus.out_valid  = (state_reg == DONE);
    assign bus.out_result = {26'd0, count_reg};
    assign busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_bitscan_unit.sv
// Directed + randomized bench for bitscan_unit against a bit-loop reference model.
module tb_bitscan_unit;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = 32 / CHUNK;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;
    int   vectors = 0;
    int   miscompares = 0;

    bitscan_if bus();

    bitscan_unit #(.CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_result(input logic [1:0] op, input logic [31:0] d);
        int n = 0;
        case (op)
            2'b00: begin
                for (int i = 31; i >= 0; i--) begin
                    if (d[i]) break;
                    n++;
                end
            end
            2'b01: begin
                for (int i = 0; i < 32; i++) begin
                    if (d[i]) break;
                    n++;
                end
            end
            2'b10: n = $countones(d);
            default: n = 0;
        endcase
        return n;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] d);
`ifdef BITSCAN_EARLY_EXIT_EN
        if (op[1] == 1'b0 && d != 32'd0) return ref_result(op, d) / CHUNK + 1;
`endif
        return NCHUNK;
    endfunction

    // Issue one op, measure latency, hold backpressure for 'hold' cycles, then retire it.
    task automatic do_op(input logic [1:0] op, input logic [31:0] d, input int hold);
        int exp_res = ref_result(op, d);
        int exp_lat = ref_latency(op, d);
        int lat = 0;
        check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 2'($urandom);
        bus.in_data  = $urandom;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 64);
        check("latency", lat, exp_lat);
        check("result", bus.out_result, exp_res);
        check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_result", bus.out_result, exp_res);
            check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("retire_valid", {31'd0, bus.out_valid}, 32'd0);
        check("retire_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b0;
        $display("op=%0d data=%08h result=%0d latency=%0d hold=%0d", op, d, exp_res, lat, hold);
    endtask

    task automatic expect_no_result(input string tag, input int cycles);
        logic saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw = 1'b1;
        end
        check(tag, {31'd0, saw}, 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] d;
        bus.in_valid = 1'b0;
        bus.in_op = 2'b00;
        bus.in_data = 32'd0;
        bus.out_ready = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", bus.out_result, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(2'b00, 32'h0001_0000, 0);
        do_op(2'b01, 32'h0001_0000, 0);
        do_op(2'b10, 32'hF0F0_0001, 0);
        do_op(2'b00, 32'h0000_0000, 0);
        do_op(2'b01, 32'h0000_0000, 0);
        do_op(2'b10, 32'h0000_0000, 0);
        do_op(2'b00, 32'hFFFF_FFFF, 0);
        do_op(2'b01, 32'hFFFF_FFFF, 0);
        do_op(2'b10, 32'hFFFF_FFFF, 0);
        do_op(2'b11, 32'h1234_5678, 0);
        do_op(2'b10, 32'h0000_00FF, 5);
        do_op(2'b00, 32'h8000_0000, 0);
        do_op(2'b00, 32'h0000_0001, 0);

        // Flush three edges after accepting CLZ 0x1.
        bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_data = 32'h1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        expect_no_result("flush_no_result", 12);
        $display("flush after CLZ 0x1 issued");
        bus.out_ready = 1'b0;
        do_op(2'b00, 32'h0000_0001, 0);

        // in_valid coincident with flush must not be accepted.
        bus.in_valid = 1'b1; bus.in_op = 2'b10; bus.in_data = 32'hFFFF; flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; flush = 1'b0;
        check("flush_reject_busy", {31'd0, busy}, 32'd0);
        expect_no_result("flush_reject_no_result", 12);

        // Asynchronous reset mid-RUN.
        bus.in_valid = 1'b1; bus.in_op = 2'b10; bus.in_data = 32'hFFFF_0000; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_result", bus.out_result, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        expect_no_result("arst_no_result", 12);
        $display("reset pulsed mid-RUN");
        bus.out_ready = 1'b0;

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: d = 32'd0;
                1: d = 32'hFFFF_FFFF;
                default: d = ($urandom >> $urandom_range(0, 31)) << $urandom_range(0, 31);
            endcase
            do_op(op, d, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
